// File: rtl/pll_phase_step_arb.sv
// Round-robin arbiter sharing one PLL dynamic phase-shift port between NREQ requesters.
// Steps are issued one at a time over the PhaseStep/PhaseDone handshake with a per-edge timeout.
//
// state | meaning
// IDLE  | no owner; arbitrate when no ack/err pulse is on the outputs
// STEP  | PhaseStep high, waiting for synchronised PhaseDone to fall
// WAITD | PhaseStep low, waiting for synchronised PhaseDone to rise
// ACK   | last step done (or zero count); pulse ack and release the port
module pll_phase_step_arb #(
    parameter int NREQ    = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*CNT_W-1:0] req_cnt,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       err,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [CNT_W-1:0]      steps_left,
    output logic                  PhaseStep,
    output logic                  PhaseUpDown,
    input  logic                  PhaseDone
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, STEP, WAITD, ACK} state_t;

    state_t            state;
    logic [1:0]        done_sync;
    logic              done_s;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     win;
    logic              win_vld;
    logic [NREQ-1:0]   win_oh;
    logic [CNT_W-1:0]  win_cnt;
    logic [PW-1:0]     ptr_after;
    logic [TW-1:0]     tmo;
    logic              abort;

    assign done_s = done_sync[1];

    // Two passes give the first set bit at or above ptr, then wrap to the bottom.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!win_vld && req[j] && (j >= int'(ptr))) begin
                win_vld = 1'b1;
                win     = PW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!win_vld && req[j]) begin
                win_vld = 1'b1;
                win     = PW'(j);
            end
        end
    end

    always_comb begin
        win_oh  = '0;
        win_cnt = '0;
        for (int j = 0; j < NREQ; j++) begin
            win_oh[j] = (win == PW'(j));
            if (win == PW'(j)) begin
                win_cnt = req_cnt[j*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        ptr_after = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        abort     = (tmo == TMO_LAST) &&
                    (((state == STEP) && done_s) || ((state == WAITD) && !done_s));
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            done_sync   <= 2'b11;
            ptr         <= '0;
            gidx        <= '0;
            tmo         <= '0;
            ack         <= '0;
            err         <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            steps_left  <= '0;
            PhaseStep   <= 1'b0;
            PhaseUpDown <= 1'b0;
        end else begin
            done_sync <= {done_sync[0], PhaseDone};
            ack       <= '0;
            err       <= '0;
            tmo       <= (tmo == TMO_MAX) ? tmo : tmo + 1'b1;

            if (abort) begin
                PhaseStep <= 1'b0;
                ack       <= grant;
                err       <= grant;
                grant     <= '0;
                busy      <= 1'b0;
                ptr       <= ptr_after;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        // Holding off while ack is visible keeps the acked requester from re-winning.
                        if (win_vld && (ack == '0)) begin
                            grant       <= win_oh;
                            gidx        <= win;
                            busy        <= 1'b1;
                            PhaseUpDown <= |(req_dir & win_oh);
                            steps_left  <= win_cnt;
                            tmo         <= '0;
                            if (win_cnt == '0) begin
                                state <= ACK;
                            end else begin
                                PhaseStep <= 1'b1;
                                state     <= STEP;
                            end
                        end
                    end
                    STEP: begin
                        if (!done_s) begin
                            PhaseStep <= 1'b0;
                            tmo       <= '0;
                            state     <= WAITD;
                        end
                    end
                    WAITD: begin
                        if (done_s) begin
                            steps_left <= (steps_left == '0) ? '0 : steps_left - 1'b1;
                            tmo        <= '0;
                            if (steps_left <= CNT_W'(1)) begin
                                state <= ACK;
                            end else begin
                                PhaseStep <= 1'b1;
                                state     <= STEP;
                            end
                        end
                    end
                    ACK: begin
                        ack   <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_after;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_phase_step_arb.sv
// Bench for pll_phase_step_arb: vector table, hand-written corner sequences and a
// randomized phase checked by a transaction-level round-robin model.
module tb_pll_phase_step_arb;

    localparam int NREQ    = 3;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic                  clock = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*CNT_W-1:0] req_cnt;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       err;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [CNT_W-1:0]      steps_left;
    logic                  PhaseStep;
    logic                  PhaseUpDown;
    logic                  PhaseDone;

    pll_phase_step_arb #(.NREQ(NREQ), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .rst(rst), .req(req), .req_dir(req_dir), .req_cnt(req_cnt),
        .ack(ack), .err(err), .grant(grant), .busy(busy), .steps_left(steps_left),
        .PhaseStep(PhaseStep), .PhaseUpDown(PhaseUpDown), .PhaseDone(PhaseDone)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    bit pll_dead = 1'b0;
    bit pll_rnd  = 1'b0;
    int d_drop   = 3;
    int d_rise   = 5;

    int               last_pulses;
    int               last_hi;
    int               last_g2a;
    logic [NREQ-1:0]  last_ack;
    logic [NREQ-1:0]  last_err;
    logic [CNT_W-1:0] last_left;
    bit               last_dir_ok;
    int               left_q[$];

    // Transaction-level model state for the random phase
    bit                    mon_en   = 1'b0;
    bit                    m_active = 1'b0;
    bit                    m_prev;
    bit                    m_dir;
    int                    m_ptr    = 0;
    int                    m_idx;
    int                    m_cnt;
    int                    m_pulses;
    int                    m_ops    = 0;
    logic [NREQ-1:0]       snap_req = '0;
    logic [NREQ-1:0]       snap_dir = '0;
    logic [NREQ*CNT_W-1:0] snap_cnt = '0;

    typedef struct {
        logic [NREQ-1:0]  r;
        logic [NREQ-1:0]  d;
        logic [CNT_W-1:0] c;
        int               idx;
        int               steps;
        bit               dead;
        bit               drop;
        int               left;
    } vec_t;

    vec_t tv[8];

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cnt_all(input logic [CNT_W-1:0] c);
        for (int k = 0; k < NREQ; k++) req_cnt[k*CNT_W +: CNT_W] = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        bit got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            tick();
            if (grant != '0) got = 1'b1;
        end
        check("wait_grant_bound", got, 1);
        g = grant;
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a);
        bit got = 1'b0;
        for (int t = 0; t < 800 && !got; t++) begin
            tick();
            if (ack != '0) got = 1'b1;
        end
        check("wait_ack_bound", got, 1);
        a = ack;
    endtask

    // Drives one request pattern, checks the grant, then follows the operation to its ack.
    task automatic run_op(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d,
                          input logic [CNT_W-1:0] c, input int exp_idx, input bit drop_mid);
        logic [NREQ-1:0] g;
        bit              got;
        logic            prev;
        req_dir = d;
        set_cnt_all(c);
        req = r;
        wait_grant(g);
        check("grant_idx", g, oh(exp_idx));
        check("busy_at_grant", busy, 1);
        check("step_at_grant", PhaseStep, (c != '0));
        check("dir_at_grant", PhaseUpDown, d[exp_idx]);
        left_q.delete();
        last_pulses = PhaseStep ? 1 : 0;
        last_hi     = PhaseStep ? 1 : 0;
        if (PhaseStep) left_q.push_back(int'(steps_left));
        prev        = PhaseStep;
        last_dir_ok = 1'b1;
        last_g2a    = 0;
        got         = 1'b0;
        if (drop_mid) req = req & ~oh(exp_idx);
        for (int t = 0; t < 800 && !got; t++) begin
            tick();
            last_g2a++;
            if (ack != '0) begin
                got = 1'b1;
            end else begin
                if (PhaseStep && !prev) begin
                    last_pulses++;
                    left_q.push_back(int'(steps_left));
                end
                if (PhaseStep) last_hi++;
                if (PhaseUpDown !== d[exp_idx]) last_dir_ok = 1'b0;
                prev = PhaseStep;
            end
        end
        check("ack_seen", got, 1);
        last_ack  = ack;
        last_err  = err;
        last_left = steps_left;
        check("grant_clear_at_ack", grant, 0);
        check("busy_clear_at_ack", busy, 0);
        check("step_low_at_ack", PhaseStep, 0);
        check("dir_stable", last_dir_ok, 1);
        req = '0;
        tick();
        tick();
    endtask

    // PLL model: PhaseDone falls d_drop cycles after PhaseStep is seen, rises d_rise later.
    initial begin
        PhaseDone = 1'b1;
        forever begin
            @(negedge clock);
            if (PhaseStep && !pll_dead) begin
                if (pll_rnd) begin
                    d_drop = int'($urandom_range(1, 4));
                    d_rise = int'($urandom_range(3, 6));
                end
                repeat (d_drop) @(negedge clock);
                PhaseDone = 1'b0;
                repeat (d_rise) @(negedge clock);
                PhaseDone = 1'b1;
            end
        end
    end

    // Round-robin reference: winner is the first requester at or after the pointer in the
    // request snapshot taken just before the granting edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (grant != '0 && !m_active) begin
                m_idx = -1;
                for (int k = 0; k < NREQ; k++)
                    if (m_idx < 0 && snap_req[(m_ptr + k) % NREQ]) m_idx = (m_ptr + k) % NREQ;
                check("mon_grant", grant, (m_idx >= 0) ? oh(m_idx) : '0);
                if (m_idx < 0) m_idx = 0;
                m_cnt    = int'(snap_cnt[m_idx*CNT_W +: CNT_W]);
                m_dir    = snap_dir[m_idx];
                m_pulses = PhaseStep ? 1 : 0;
                m_prev   = PhaseStep;
                m_active = 1'b1;
                check("mon_dir", PhaseUpDown, m_dir);
            end else if (m_active && ack == '0) begin
                if (PhaseStep && !m_prev) m_pulses++;
                m_prev = PhaseStep;
                check("mon_dir_hold", PhaseUpDown, m_dir);
            end
            if (ack != '0) begin
                check("mon_ack", ack, m_active ? oh(m_idx) : '0);
                check("mon_err", err, 0);
                check("mon_pulses", m_pulses, m_cnt);
                check("mon_left", steps_left, 0);
                m_ptr    = (m_idx + 1) % NREQ;
                m_active = 1'b0;
                m_ops++;
            end
            check("mon_onehot", $onehot0(grant), 1);
            snap_req = req;
            snap_dir = req_dir;
            snap_cnt = req_cnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] a;
        int              pulses;
        logic            prev;
        bit              seen;

        tv[0] = '{3'b001, 3'b001, 8'd1, 0, 1, 1'b0, 1'b0, 0};
        tv[1] = '{3'b010, 3'b000, 8'd4, 1, 4, 1'b0, 1'b1, 0};
        tv[2] = '{3'b011, 3'b011, 8'd2, 0, 2, 1'b0, 1'b0, 0};
        tv[3] = '{3'b011, 3'b010, 8'd2, 1, 2, 1'b0, 1'b0, 0};
        tv[4] = '{3'b101, 3'b100, 8'd0, 2, 0, 1'b0, 1'b0, 0};
        tv[5] = '{3'b111, 3'b001, 8'd1, 0, 1, 1'b1, 1'b0, 1};
        tv[6] = '{3'b111, 3'b010, 8'd1, 1, 1, 1'b0, 1'b0, 0};
        tv[7] = '{3'b110, 3'b100, 8'd3, 2, 3, 1'b0, 1'b0, 0};

        rst     = 1'b1;
        req     = '0;
        req_dir = '0;
        req_cnt = '0;
        tick();
        tick();
        check("reset_outputs", {ack, err, grant, busy, steps_left, PhaseStep, PhaseUpDown}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            pll_dead = tv[i].dead;
            run_op(tv[i].r, tv[i].d, tv[i].c, tv[i].idx, tv[i].drop);
            check("ack_idx", last_ack, oh(tv[i].idx));
            check("err", last_err, tv[i].dead ? oh(tv[i].idx) : '0);
            check("pulses", last_pulses, tv[i].steps);
            check("left_at_ack", last_left, tv[i].left);
            if (tv[i].dead) check("timeout_high_cycles", last_hi, TIMEOUT);
            if (tv[i].c == '0) check("zero_ack_latency", (last_g2a <= 2), 1);
            if (tv[i].steps == 4) begin
                check("left_seq_len", left_q.size(), 4);
                for (int k = 0; k < left_q.size(); k++) check("left_seq", left_q[k], 4 - k);
            end
            pll_dead = 1'b0;
        end

        // Contention: requester 0 wins from pointer 0, then 1; 0 re-requests during 1's turn.
        do_reset();
        req_dir = '0;
        set_cnt_all(8'd2);
        req = 3'b011;
        wait_grant(g);
        check("cont_first_grant", g, 3'b001);
        wait_ack(a);
        req[0] = 1'b0;
        check("cont_first_ack", a, 3'b001);
        wait_grant(g);
        check("cont_second_grant", g, 3'b010);
        tick();
        tick();
        req[0] = 1'b1;
        wait_ack(a);
        req[1] = 1'b0;
        check("cont_second_ack", a, 3'b010);
        wait_grant(g);
        check("cont_third_grant", g, 3'b001);
        wait_ack(a);
        req = '0;
        check("cont_third_ack", a, 3'b001);
        tick();
        tick();

        // Reset during the second step of a three-step operation.
        do_reset();
        req_dir = 3'b001;
        set_cnt_all(8'd3);
        req = 3'b001;
        wait_grant(g);
        pulses = PhaseStep ? 1 : 0;
        prev   = PhaseStep;
        for (int t = 0; t < 200 && pulses < 2; t++) begin
            tick();
            if (PhaseStep && !prev) pulses++;
            prev = PhaseStep;
        end
        check("rst_reached_second_step", pulses, 2);
        rst = 1'b1;
        tick();
        check("rst_midop_outputs", {ack, err, grant, busy, steps_left, PhaseStep, PhaseUpDown}, 0);
        rst  = 1'b0;
        req  = '0;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (ack != '0) seen = 1'b1;
        end
        check("rst_no_ack", seen, 0);
        run_op(3'b001, 3'b001, 8'd1, 0, 1'b0);
        check("rst_fresh_ack", last_ack, 3'b001);
        check("rst_fresh_err", last_err, 0);
        check("rst_fresh_pulses", last_pulses, 1);

        // Randomized traffic against the round-robin model.
        do_reset();
        pll_rnd = 1'b1;
        m_ptr   = 0;
        mon_en  = 1'b1;
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                end else if (!req[i]) begin
                    req_dir[i] = 1'($urandom_range(0, 1));
                    req_cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
                    req[i] = ($urandom_range(0, 5) == 0);
                end else if (grant[i]) begin
                    req_dir[i] = 1'($urandom_range(0, 1));
                    req_cnt[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
                end
            end
            tick();
        end
        req  = '0;
        seen = 1'b0;
        for (int t = 0; t < 800 && !seen; t++) begin
            tick();
            if (!busy && ack == '0) seen = 1'b1;
        end
        check("random_drain", seen, 1);
        tick();
        tick();
        mon_en = 1'b0;
        check("random_ops_done", (m_ops >= 20), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
